z80_port_uart: RTL and testbench
================================

// Module: z80_port_uart
// PURPOSE
//  UART peripheral on the Z80 I/O port bus: responds to CPU IN/OUT cycles and exposes data, status and control registers.
//  Serialises CPU-written bytes onto o_tx and deserialises i_rx into an RX FIFO read back through the data port.
//  Sits beside the program RAM at top level; o_port_in is OR/muxed into the CPU port_in path when o_port_sel=1.
// PARAMETERS
//  BASE_PORT   8'hF0  low address byte of register block; decode on i_port[7:0], occupies BASE..BASE+2
//  DIVISOR     217    i_clk cycles per bit (25 MHz / 115200), >=4
//  FIFO_DEPTH  16     RX (and TX, if enabled) FIFO entries; power of two, >=2
// PORTS
//  i_clk       in   1   single clock, all logic on posedge
//  i_rst_n     in   1   synchronous reset, active-low
//  i_port      in   16  CPU port address
//  i_port_out  in   8   CPU OUT data
//  i_port_clk  in   1   one-cycle OUT (write) strobe
//  i_port_rd   in   1   one-cycle IN (read) strobe, asserted in the cycle the CPU samples o_port_in
//  o_port_in   out  8   registered read data
//  o_port_sel  out  1   combinational: i_port[7:0] in BASE..BASE+2
//  i_rx        in   1   serial input, asynchronous, idle high
//  o_tx        out  1   serial output, idle high
//  o_irq       out  1   registered RX interrupt request
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): o_tx=1, o_port_in=8'hFF, o_irq=0, FIFOs empty, all flags/ctrl=0, TX/RX FSMs IDLE, counters 0.
//  Registers: +0 DATA  W: TX load; R: RX FIFO head (8'h00 if empty), pop on i_port_rd.
//   +1 STATUS (RO): b0 rx_avail, b1 tx_busy, b2 rx_overrun, b3 frame_err, b4 tx_full, b7 rx_full, others 0.
//   +2 CTRL: b0 rx_irq_en (R/W); write with b7=1 clears overrun+frame_err (b7 reads 0).
//  Read path: o_port_in <= mux(i_port[7:0]) every cycle; unmapped address -> 8'hFF; latency 1 cycle.
//  Pop on DATA read at i_port_rd when non-empty; o_port_in already holds the head value before the pop.
//  Write: acts only at i_port_clk with a mapped address; writes to STATUS ignored.
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each state lasts DIVISOR cycles; o_tx registered.
//  tx_busy=1 from the cycle after load until STOP ends; back-to-back transmission with no idle gap when next byte pending.
//  RX: 2-flop synchroniser; IDLE on sync falling edge -> START, recheck at DIVISOR/2 (high -> IDLE, glitch rejected).
//   DATA samples 8 bits at DIVISOR intervals from mid-start; STOP sample: low -> frame_err=1, byte discarded.
//  RX push when FIFO full -> byte discarded, overrun=1; push and pop same cycle while full -> both succeed, no overrun.
//  Flags are sticky until CTRL clear; clear and new error in same cycle -> flag stays 1.
//  o_irq <= rx_irq_en & rx_avail.
//  Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
//  Reset mid-frame: frame aborted, o_tx=1 next cycle, partial RX byte dropped.
// CONFIGURATION
//  Z80_UART_TXFIFO_EN defined: DATA writes push a FIFO_DEPTH TX FIFO; write when full dropped; tx_full = FIFO full.
//  Undefined: single holding register; write accepted only when TX IDLE and holding reg empty, else dropped; tx_full = tx_busy.
// STRUCTURE
//  z80_uart_pkg: register offsets, STATUS/CTRL bit indices, TX/RX state encodings.
//  Sub-module z80_uart_fifo (sync FIFO, push/pop/full/empty/head), instanced for RX and, with macro, for TX.
//  Baud counters and both FSMs live in z80_port_uart.
// TESTING (DIVISOR=4, BASE_PORT=8'hF0, FIFO_DEPTH=4)
//  Reset: hold i_rst_n=0 2 cycles -> o_tx=1, o_irq=0, o_port_in=FF; IN F1 -> 8'h00.
//  OUT F0,8'hA5 -> o_tx: 0,1,0,1,0,0,1,0,1,1, each 4 cycles; STATUS b1=1 during, 0 after.
//  Drive i_rx frame 8'h3C, OUT F2,01 -> o_irq=1; IN F0 -> 8'h3C; next STATUS b0=0, o_irq=0.
//  Send 5 RX bytes without reads -> STATUS=8'h85; read 4 bytes in order; OUT F2,80 -> b2 cleared.
//  RX frame with low stop bit -> frame_err=1, FIFO unchanged; 1-cycle low glitch on i_rx -> no byte, no error.
//  Macro on: 3 back-to-back OUT F0 -> 30 contiguous bit times; macro off: 2nd/3rd writes dropped. IN F7 -> 8'hFF.

Source files
------------

// File: rtl/z80_uart_pkg.sv
// z80_uart_pkg: shared definitions for the Z80 port-mapped UART.
//   Register offsets within the three-port block, STATUS/CTRL bit indices,
//   and the TX/RX state encodings used by z80_port_uart.
package z80_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int unsigned ST_RX_AVAIL  = 0;
    localparam int unsigned ST_TX_BUSY   = 1;
    localparam int unsigned ST_OVERRUN   = 2;
    localparam int unsigned ST_FRAME_ERR = 3;
    localparam int unsigned ST_TX_FULL   = 4;
    localparam int unsigned ST_RX_FULL   = 7;

    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_CLR    = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/z80_uart_fifo.sv
// z80_uart_fifo: synchronous FIFO with show-ahead head output.
//   i_clk/i_rst_n : clock, synchronous active-low reset
//   i_push/i_din  : write request and data (ignored when full unless popping)
//   i_pop         : read request (ignored when empty)
//   o_head        : entry at the read pointer
//   o_full/o_empty: occupancy flags
module z80_uart_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push_c;
    logic             do_pop_c;

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_pop_c  = i_pop & ~o_empty;
    assign do_push_c = i_push & (~o_full | do_pop_c);
    assign o_full    = (count == (AW + 1)'(DEPTH));
    assign o_empty   = (count == '0);
    assign o_head    = mem[rd_ptr];

    // Storage array, no reset needed.
    always_ff @(posedge i_clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push_c, do_pop_c})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/z80_port_uart.sv
// z80_port_uart: UART on the Z80 I/O port bus (DATA/STATUS/CTRL at BASE_PORT+0..2).
//   i_clk, i_rst_n         : clock, synchronous active-low reset
//   i_port, i_port_out     : CPU port address / OUT data
//   i_port_clk, i_port_rd  : one-cycle OUT and IN strobes
//   o_port_in              : registered read data (8'hFF when unmapped)
//   o_port_sel             : combinational address match
//   i_rx, o_tx             : serial lines, idle high
//   o_irq                  : registered RX interrupt
// Build option Z80_UART_TXFIFO_EN: DATA writes go to a FIFO_DEPTH TX FIFO
//   instead of a single holding register.
module z80_port_uart
    import z80_uart_pkg::*;
#(
    parameter logic [7:0]  BASE_PORT  = 8'hF0,
    parameter int unsigned DIVISOR    = 217,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_port,
    input  logic [7:0]  i_port_out,
    input  logic        i_port_clk,
    input  logic        i_port_rd,
    output logic [7:0]  o_port_in,
    output logic        o_port_sel,
    input  logic        i_rx,
    output logic        o_tx,
    output logic        o_irq
);

    localparam int unsigned       CNT_W    = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIVISOR / 2 - 1);

    // Address decode; only the low address byte matters.
    logic [7:0] offset_c;
    logic [1:0] reg_c;
    logic       unused_hi_c;
    logic       wr_data_c, wr_ctrl_c, clr_c, rd_pop_c;

    assign unused_hi_c = ^i_port[15:8];
    assign offset_c    = i_port[7:0] - BASE_PORT;
    assign o_port_sel  = (offset_c < 8'd3);
    assign reg_c       = offset_c[1:0];
    assign wr_data_c   = i_port_clk & o_port_sel & (reg_c == REG_DATA);
    assign wr_ctrl_c   = i_port_clk & o_port_sel & (reg_c == REG_CTRL);
    assign clr_c       = wr_ctrl_c & i_port_out[CTRL_CLR];

    tx_state_e        tx_state, tx_state_nx;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0]       tx_bit, tx_bit_nx;
    logic [7:0]       tx_shift, tx_shift_nx;
    logic             tx_line_nx, tx_load_c, tx_pending_c, tx_busy_c, tx_full_c;
    logic [7:0]       tx_pend_data_c;

    rx_state_e        rx_state, rx_state_nx;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0]       rx_bit, rx_bit_nx;
    logic [7:0]       rx_shift, rx_shift_nx;
    logic [2:0]       rx_sync;
    logic             rx_fall_c, rx_push_c, frame_set_c, ovr_set_c;
    logic             rx_full, rx_empty;
    logic [7:0]       rx_head;

    logic             rx_irq_en, overrun, frame_err;
    logic [7:0]       status_c, rd_mux_c;

    assign rd_pop_c = i_port_rd & o_port_sel & (reg_c == REG_DATA) & ~rx_empty;

    // TX byte source: FIFO or single holding register.
`ifdef Z80_UART_TXFIFO_EN
    logic tx_fifo_empty, tx_fifo_full;

    z80_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (wr_data_c),
        .i_pop   (tx_load_c),
        .i_din   (i_port_out),
        .o_head  (tx_pend_data_c),
        .o_full  (tx_fifo_full),
        .o_empty (tx_fifo_empty)
    );

    assign tx_pending_c = ~tx_fifo_empty;
    assign tx_busy_c    = (tx_state != TX_IDLE) | tx_pending_c;
    assign tx_full_c    = tx_fifo_full;
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    // Holding register accepts a byte only when the transmitter is fully idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (tx_load_c) begin
            hold_valid <= 1'b0;
        end else if (wr_data_c && tx_state == TX_IDLE && !hold_valid) begin
            hold_valid <= 1'b1;
            hold_data  <= i_port_out;
        end
    end

    assign tx_pending_c   = hold_valid;
    assign tx_pend_data_c = hold_data;
    assign tx_busy_c      = (tx_state != TX_IDLE) | hold_valid;
    assign tx_full_c      = tx_busy_c;
`endif

    z80_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (rx_push_c),
        .i_pop   (rd_pop_c),
        .i_din   (rx_shift),
        .o_head  (rx_head),
        .o_full  (rx_full),
        .o_empty (rx_empty)
    );

    // TX next-state; a pending byte at STOP end starts the next frame directly.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        tx_load_c   = 1'b0;
        tx_line_nx  = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                if (tx_pending_c) begin
                    tx_load_c   = 1'b1;
                    tx_shift_nx = tx_pend_data_c;
                    tx_cnt_nx   = '0;
                    tx_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = TX_DATA;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = {1'b0, tx_shift[7:1]};
                    tx_bit_nx   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_nx = TX_STOP;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (tx_cnt == CNT_LAST) begin
                    tx_cnt_nx = '0;
                    if (tx_pending_c) begin
                        tx_load_c   = 1'b1;
                        tx_shift_nx = tx_pend_data_c;
                        tx_state_nx = TX_START;
                    end else begin
                        tx_state_nx = TX_IDLE;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
        endcase
        // Line level follows the state being entered so o_tx is a clean register.
        if (tx_state_nx == TX_START)     tx_line_nx = 1'b0;
        else if (tx_state_nx == TX_DATA) tx_line_nx = tx_shift_nx[0];
    end

    // RX next-state; start is re-checked mid-bit, then one sample per bit time.
    assign rx_fall_c = rx_sync[2] & ~rx_sync[1];

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_push_c   = 1'b0;
        frame_set_c = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_fall_c) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_sync[1] ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync[1], rx_shift[7:1]};
                    rx_bit_nx   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_nx = RX_STOP;
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = RX_IDLE;
                    rx_push_c   = rx_sync[1];
                    frame_set_c = ~rx_sync[1];
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
        endcase
    end

    assign ovr_set_c = rx_push_c & rx_full & ~rd_pop_c;

    // FSM and serial line registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            o_tx     <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_sync  <= 3'b111;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            o_tx     <= tx_line_nx;
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_sync  <= {rx_sync[1:0], i_rx};
        end
    end

    always_comb begin
        status_c               = '0;
        status_c[ST_RX_AVAIL]  = ~rx_empty;
        status_c[ST_TX_BUSY]   = tx_busy_c;
        status_c[ST_OVERRUN]   = overrun;
        status_c[ST_FRAME_ERR] = frame_err;
        status_c[ST_TX_FULL]   = tx_full_c;
        status_c[ST_RX_FULL]   = rx_full;
    end

    always_comb begin
        rd_mux_c = 8'hFF;
        if (o_port_sel) begin
            unique case (reg_c)
                REG_DATA:   rd_mux_c = rx_empty ? 8'h00 : rx_head;
                REG_STATUS: rd_mux_c = status_c;
                REG_CTRL:   rd_mux_c = {7'b0, rx_irq_en};
                default:    rd_mux_c = 8'hFF;
            endcase
        end
    end

    // Register file, sticky flags (a new error beats a clear) and read/irq outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rx_irq_en <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            o_port_in <= 8'hFF;
            o_irq     <= 1'b0;
        end else begin
            if (wr_ctrl_c) rx_irq_en <= i_port_out[CTRL_IRQ_EN];
            overrun   <= ovr_set_c   | (overrun   & ~clr_c);
            frame_err <= frame_set_c | (frame_err & ~clr_c);
            o_port_in <= rd_mux_c;
            o_irq     <= rx_irq_en & ~rx_empty;
        end
    end

endmodule

// File: tb/tb_z80_port_uart.sv
// tb_z80_port_uart: directed/randomised bench for z80_port_uart
//   (DIVISOR=4, BASE_PORT=8'hF0, FIFO_DEPTH=4), with a queue-based model of
//   the register block and per-cycle expected serial waveforms.
module tb_z80_port_uart;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] port;
    logic [7:0]  port_out;
    logic        port_clk;
    logic        port_rd;
    logic [7:0]  port_in;
    logic        port_sel;
    logic        rx;
    logic        tx;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_q[$];
    logic       m_over, m_frame, m_irq_en, m_busy;

    always #5 clk = ~clk;

    z80_port_uart #(.BASE_PORT(8'hF0), .DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_port     (port),
        .i_port_out (port_out),
        .i_port_clk (port_clk),
        .i_port_rd  (port_rd),
        .o_port_in  (port_in),
        .o_port_sel (port_sel),
        .i_rx       (rx),
        .o_tx       (tx),
        .o_irq      (irq)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic txf;
`ifdef Z80_UART_TXFIFO_EN
        txf = 1'b0;
`else
        txf = m_busy;
`endif
        return {m_q.size() == DEPTH, 2'b00, txf, m_frame, m_over, m_busy, m_q.size() != 0};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_over = 0; m_frame = 0; m_irq_en = 0; m_busy = 0;
    endtask

    task automatic port_write(input logic [7:0] lo, input logic [7:0] d);
        @(negedge clk);
        port = {8'($urandom), lo}; port_out = d; port_clk = 1'b1;
        @(negedge clk);
        port_clk = 1'b0; port = 16'h0000;
        if (lo == 8'hF2) begin
            m_irq_en = d[0];
            if (d[7]) begin m_over = 0; m_frame = 0; end
        end
    endtask

    task automatic rd_check(input logic [7:0] lo, input string tag);
        logic [7:0] exp;
        logic [7:0] got;
        case (lo)
            8'hF0:   exp = (m_q.size() != 0) ? m_q[0] : 8'h00;
            8'hF1:   exp = exp_status();
            8'hF2:   exp = {7'b0, m_irq_en};
            default: exp = 8'hFF;
        endcase
        @(negedge clk);
        port = {8'($urandom), lo};
        @(negedge clk);
        port_rd = 1'b1;
        got = port_in;
        @(negedge clk);
        port_rd = 1'b0; port = 16'h0000;
        check(tag, got, exp);
        if (lo == 8'hF0 && m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        if (!stop_bit)                m_frame = 1;
        else if (m_q.size() == DEPTH) m_over = 1;
        else                          m_q.push_back(d);
    endtask

    task automatic check_irq(input string tag);
        check(tag, {7'b0, irq}, {7'b0, m_irq_en && (m_q.size() != 0)});
    endtask

    // n back-to-back DATA writes, then per-cycle comparison of o_tx with the expected frames.
    task automatic tx_burst(input int n, input logic [7:0] first, input string tag);
        logic [7:0] b[3];
        logic       bits[$];
        int         acc;
        b[0] = first;
        for (int i = 1; i < 3; i++) b[i] = 8'($urandom);
`ifdef Z80_UART_TXFIFO_EN
        acc = n;
`else
        acc = 1;
`endif
        for (int j = 0; j < acc; j++) begin
            bits.push_back(1'b0);
            for (int k = 0; k < 8; k++) bits.push_back(b[j][k]);
            bits.push_back(1'b1);
        end
        @(negedge clk);
        port = 16'h00F0; port_out = b[0]; port_clk = 1'b1;
        fork
            begin
                for (int j = 1; j < n; j++) begin
                    @(negedge clk);
                    port_out = b[j];
                end
                @(negedge clk);
                port_clk = 1'b0; port = 16'h0000;
            end
            begin
                for (int k = 0; k < 1 + DIV * bits.size() + 8; k++) begin
                    logic e;
                    @(negedge clk);
                    if (k >= 1 && (k - 1) / DIV < bits.size()) e = bits[(k - 1) / DIV];
                    else                                      e = 1'b1;
                    check(tag, {7'b0, tx}, {7'b0, e});
                end
            end
        join
    endtask

    initial begin
        rst_n = 1'b0; port = 16'h0000; port_out = 8'h00;
        port_clk = 1'b0; port_rd = 1'b0; rx = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tx", {7'b0, tx}, 8'h01);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_port_in", port_in, 8'hFF);
        rst_n = 1'b1;
        rd_check(8'hF1, "rst_status");
        rd_check(8'hF2, "rst_ctrl");
        rd_check(8'hF0, "rst_data_empty");

        // Address decode on the low byte only.
        @(negedge clk); port = 16'h00F2; #1 check("sel_f2", {7'b0, port_sel}, 8'h01);
        @(negedge clk); port = 16'hABF0; #1 check("sel_abf0", {7'b0, port_sel}, 8'h01);
        @(negedge clk); port = 16'h00F3; #1 check("sel_f3", {7'b0, port_sel}, 8'h00);
        @(negedge clk); port = 16'h00EF; #1 check("sel_ef", {7'b0, port_sel}, 8'h00);
        port = 16'h0000;

        tx_burst(1, 8'hA5, "tx_a5");
        tx_burst(1, 8'($urandom), "tx_rand");

        port_write(8'hF0, 8'($urandom));
        m_busy = 1;
        rd_check(8'hF1, "status_busy");
        repeat (60) @(negedge clk);
        m_busy = 0;
        rd_check(8'hF1, "status_idle");

        rx_send(8'h3C, 1'b1);
        port_write(8'hF2, 8'h01);
        repeat (2) @(negedge clk);
        check_irq("irq_on");
        rd_check(8'hF2, "ctrl_en");
        rd_check(8'hF0, "rx_3c");
        rd_check(8'hF1, "status_after_pop");
        repeat (2) @(negedge clk);
        check_irq("irq_off");

        for (int i = 0; i < 5; i++) rx_send(8'($urandom), 1'b1);
        rd_check(8'hF1, "status_full_ovr");
        check_irq("irq_full");
        for (int i = 0; i < 4; i++) rd_check(8'hF0, "rx_fifo_order");
        rd_check(8'hF1, "status_ovr_sticky");
        port_write(8'hF2, 8'h80);
        rd_check(8'hF1, "status_ovr_clr");
        rd_check(8'hF2, "ctrl_b7_reads0");

        rx_send(8'($urandom), 1'b0);
        rd_check(8'hF1, "status_frame");
        rd_check(8'hF0, "data_frame_drop");
        port_write(8'hF2, 8'h80);
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (20) @(negedge clk);
        rd_check(8'hF1, "status_glitch");

        tx_burst(3, 8'($urandom), "tx_burst3");
        rd_check(8'hF7, "unmapped_f7");

        port_write(8'hF2, 8'h01);
        for (int i = 0; i < 4; i++) begin
            rx_send(8'($urandom), 1'b1);
            check_irq("irq_rand");
            rd_check(8'hF0, "rx_rand");
        end

        // Reset in the middle of a TX frame and an RX frame.
        port_write(8'hF0, 8'h00);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0; rx = 1'b1;
        @(negedge clk);
        check("midrst_tx", {7'b0, tx}, 8'h01);
        rst_n = 1'b1;
        model_reset();
        repeat (50) @(negedge clk);
        check("midrst_tx_idle", {7'b0, tx}, 8'h01);
        rd_check(8'hF1, "midrst_status");
        rd_check(8'hF0, "midrst_data");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
